// File: rtl/layer_compositor.sv
// layer_compositor: fixed-priority sprite compositor with sync alignment and per-frame collision latch.
// Optional macro TRANSPARENCY_KEY_EN masks layer pixels equal to KEY_COLOR.
`default_nettype none

module layer_compositor #(
  parameter int N_LAYERS = 4,
  parameter int COLOR_W = 4,
  parameter logic [3*COLOR_W-1:0] BG_DEFAULT = 12'hFFF,
  parameter bit SYNC_POL = 1'b0,
  parameter logic [3*COLOR_W-1:0] KEY_COLOR = 12'hF0F
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            visible,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic [N_LAYERS-1:0]             layer_visible,
  input  logic [N_LAYERS*3*COLOR_W-1:0]   layer_rgb,
  input  logic                            bg_load,
  input  logic [3*COLOR_W-1:0]            bg_rgb_in,
  output logic [COLOR_W-1:0]              vga_r,
  output logic [COLOR_W-1:0]              vga_g,
  output logic [COLOR_W-1:0]              vga_b,
  output logic                            hsync_out,
  output logic                            vsync_out,
  output logic                            collision_frame,
  output logic                            collision_pulse,
  output logic [15:0]                     frame_count
);

  localparam int PIX_W = 3 * COLOR_W;

  logic                        s1_visible;
  logic                        s1_hsync;
  logic                        s1_vsync;
  logic [N_LAYERS-1:0]         s1_layer_visible;
  logic [N_LAYERS*PIX_W-1:0]   s1_layer_rgb;
  logic [PIX_W-1:0]            bg_rgb;
  logic                        collision_live;

  logic [N_LAYERS-1:0]         eff;
  logic [PIX_W-1:0]            pixel;
  logic                        hit;
  logic                        frame_edge;

`ifdef TRANSPARENCY_KEY_EN
  for (genvar i = 0; i < N_LAYERS; i++) begin : g_key
    assign eff[i] = s1_layer_visible[i] & (s1_layer_rgb[i*PIX_W +: PIX_W] != KEY_COLOR);
  end
`else
  logic unused_key;
  assign eff        = s1_layer_visible;
  assign unused_key = ^KEY_COLOR;
`endif

  // Walk from lowest priority upward so the lowest-index covering layer wins.
  always_comb begin
    pixel = bg_rgb;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (eff[i]) pixel = s1_layer_rgb[i*PIX_W +: PIX_W];
    end
    if (!s1_visible) pixel = '0;
  end

  assign hit = s1_visible & eff[0] & (|eff[N_LAYERS-1:1]);
  // vsync_out holds the previous stage-1 vsync, so it doubles as the edge-detect history.
  assign frame_edge = (s1_vsync == SYNC_POL) && (vsync_out != SYNC_POL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_visible       <= 1'b0;
      s1_hsync         <= ~SYNC_POL;
      s1_vsync         <= ~SYNC_POL;
      s1_layer_visible <= '0;
      s1_layer_rgb     <= '0;
      bg_rgb           <= BG_DEFAULT;
    end else begin
      s1_visible       <= visible;
      s1_hsync         <= hsync_in;
      s1_vsync         <= vsync_in;
      s1_layer_visible <= layer_visible;
      s1_layer_rgb     <= layer_rgb;
      if (bg_load) bg_rgb <= bg_rgb_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_r           <= '0;
      vga_g           <= '0;
      vga_b           <= '0;
      hsync_out       <= ~SYNC_POL;
      vsync_out       <= ~SYNC_POL;
      collision_live  <= 1'b0;
      collision_frame <= 1'b0;
      collision_pulse <= 1'b0;
      frame_count     <= '0;
    end else begin
      {vga_r, vga_g, vga_b} <= pixel;
      hsync_out             <= s1_hsync;
      vsync_out             <= s1_vsync;
      if (frame_edge) begin
        collision_frame <= collision_live | hit;
        collision_pulse <= collision_live | hit;
        collision_live  <= 1'b0;
        frame_count     <= frame_count + 16'd1;
      end else begin
        collision_pulse <= 1'b0;
        collision_live  <= collision_live | hit;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: table vectors, directed sequences and randomized checks against a frame-level model.
`default_nettype none

module tb_layer_compositor;

  localparam logic [11:0] BG_DEF = 12'hFFF;
  localparam logic [11:0] KEY    = 12'hF0F;
  localparam logic        ACT    = 1'b0;
`ifdef TRANSPARENCY_KEY_EN
  localparam bit KEY_ON = 1'b1;
`else
  localparam bit KEY_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        visible = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [3:0]  layer_visible = '0;
  logic [47:0] layer_rgb = '0;
  logic        bg_load = 1'b0;
  logic [11:0] bg_rgb_in = '0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync_out, vsync_out, collision_frame, collision_pulse;
  logic [15:0] frame_count;

  layer_compositor dut (
    .clock(clock), .reset_n(reset_n), .visible(visible),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .layer_visible(layer_visible), .layer_rgb(layer_rgb),
    .bg_load(bg_load), .bg_rgb_in(bg_rgb_in),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .collision_frame(collision_frame), .collision_pulse(collision_pulse),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        cf;
    logic        cp;
    logic [15:0] fc;
  } exp_t;

  typedef struct {
    logic        vis;
    logic [3:0]  lv;
    logic [47:0] rgb;
    logic [11:0] exp_rgb;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: frame-level bookkeeping plus a two-deep output delay queue.
  logic [11:0] m_bg;
  logic        m_live, m_cf, m_prev_vs;
  logic [15:0] m_fc;
  exp_t        q[$];

  function automatic exp_t reset_rec();
    exp_t r;
    r.rgb = 12'h000; r.hs = ~ACT; r.vs = ~ACT; r.cf = 1'b0; r.cp = 1'b0; r.fc = 16'd0;
    return r;
  endfunction

  function automatic logic [3:0] eff_bits(input logic [3:0] lv, input logic [47:0] rgb);
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = lv[i] && !(KEY_ON && rgb[i*12 +: 12] == KEY);
    return e;
  endfunction

  function automatic logic [11:0] pick(input logic vis, input logic [3:0] lv,
                                       input logic [47:0] rgb, input logic [11:0] bg);
    logic [3:0]  e;
    logic [11:0] c;
    logic        found;
    e = eff_bits(lv, rgb);
    c = bg;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && e[i]) begin
        c = rgb[i*12 +: 12];
        found = 1'b1;
      end
    end
    return vis ? c : 12'h000;
  endfunction

  task automatic model_reset();
    m_bg = BG_DEF; m_live = 1'b0; m_cf = 1'b0; m_prev_vs = ~ACT; m_fc = 16'd0;
    q.delete();
    q.push_back(reset_rec());
  endtask

  function automatic logic [31:0] got_all();
    return {vga_r, vga_g, vga_b, hsync_out, vsync_out, collision_frame, collision_pulse, frame_count};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    exp_t       e, nw;
    logic [3:0] ef;
    logic       hit, bnd, pulse;
    @(posedge clock);
    if (!reset_n) begin
      model_reset();
      e = reset_rec();
    end else begin
      if (bg_load) m_bg = bg_rgb_in;
      ef    = eff_bits(layer_visible, layer_rgb);
      hit   = visible && ef[0] && (ef[3:1] != 3'b000);
      bnd   = (vsync_in == ACT) && (m_prev_vs != ACT);
      pulse = 1'b0;
      if (bnd) begin
        m_cf   = m_live | hit;
        pulse  = m_cf;
        m_fc   = m_fc + 16'd1;
        m_live = 1'b0;
      end else begin
        m_live = m_live | hit;
      end
      m_prev_vs = vsync_in;
      nw.rgb = pick(visible, layer_visible, layer_rgb, m_bg);
      nw.hs = hsync_in; nw.vs = vsync_in; nw.cf = m_cf; nw.cp = pulse; nw.fc = m_fc;
      e = q.pop_front();
      q.push_back(nw);
    end
    #1;
    check("pipeline", got_all(), e);
  endtask

  task automatic set_layers(input logic [3:0] lv, input logic [11:0] l0, input logic [11:0] l1,
                            input logic [11:0] l2, input logic [11:0] l3);
    layer_visible = lv;
    layer_rgb = {l3, l2, l1, l0};
  endtask

  // Two edges with vsync active: the second leaves the boundary results on the outputs.
  task automatic boundary();
    vsync_in = ACT;
    tick();
    tick();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 4'b0000, 48'h0, 12'hFFF};
    vecs[1] = '{1'b1, 4'b0110, {12'h000, 12'hF00, 12'h00F, 12'h000}, 12'h00F};
    vecs[2] = '{1'b1, 4'b0111, {12'h000, 12'hF00, 12'h00F, 12'h0F0}, 12'h0F0};
    vecs[3] = '{1'b0, 4'b1111, {12'h111, 12'h222, 12'h333, 12'h444}, 12'h000};
    vecs[4] = '{1'b1, 4'b1000, {12'hABC, 12'h222, 12'h333, 12'h444}, 12'hABC};
    vecs[5] = '{1'b1, 4'b0100, {12'h000, 12'hF00, 12'h000, 12'h000}, 12'hF00};
    vecs[6] = '{1'b1, 4'b0011, {12'h000, 12'h000, 12'h00F, 12'hF0F}, KEY_ON ? 12'h00F : 12'hF0F};
    vecs[7] = '{1'b1, 4'b0001, {12'h000, 12'h000, 12'h000, 12'hF0F}, KEY_ON ? 12'hFFF : 12'hF0F};

    model_reset();
    tick();
    tick();

    // Reset release, plain background
    #3 reset_n = 1'b1;
    visible = 1'b1;
    set_layers(4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);
    tick();
    tick();
    check("reset_bg_rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, 12'hFFF});
    check("reset_syncs", {30'd0, hsync_out, vsync_out}, {30'd0, 2'b11});
    check("reset_fc", {16'd0, frame_count}, 32'd0);

    foreach (vecs[k]) begin
      visible = vecs[k].vis;
      layer_visible = vecs[k].lv;
      layer_rgb = vecs[k].rgb;
      tick();
      tick();
      check($sformatf("vec%0d_rgb", k), {20'd0, vga_r, vga_g, vga_b}, {20'd0, vecs[k].exp_rgb});
    end

    // Flush the collisions from the table, then a single overlapping pixel
    set_layers(4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);
    boundary();
    check("flush_cf_cp", {30'd0, collision_frame, collision_pulse}, {30'd0, 2'b11});
    check("flush_fc", {16'd0, frame_count}, 32'd1);
    vsync_in = ~ACT;
    tick();
    set_layers(4'b0011, 12'h0F0, 12'h00F, 12'h0, 12'h0);
    tick();
    set_layers(4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);
    tick();
    boundary();
    check("hit_cf_cp", {30'd0, collision_frame, collision_pulse}, {30'd0, 2'b11});
    check("hit_fc", {16'd0, frame_count}, 32'd2);
    tick();
    check("pulse_one_cycle", {30'd0, collision_frame, collision_pulse}, {30'd0, 2'b10});
    vsync_in = ~ACT;
    tick();
    tick();
    boundary();
    check("clean_cf_cp", {30'd0, collision_frame, collision_pulse}, {30'd0, 2'b00});
    check("clean_fc", {16'd0, frame_count}, 32'd3);
    tick();
    tick();
    check("held_vsync_fc", {16'd0, frame_count}, 32'd3);

    // Transparency key on layer 0
    vsync_in = ~ACT;
    set_layers(4'b0011, 12'hF0F, 12'h00F, 12'h0, 12'h0);
    tick();
    tick();
    check("key_rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, KEY_ON ? 12'h00F : 12'hF0F});
    set_layers(4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);
    boundary();
    check("key_cf", {31'd0, collision_frame}, {31'd0, !KEY_ON});
    vsync_in = ~ACT;

    // Background load mid-line
    tick();
    bg_load = 1'b1;
    bg_rgb_in = 12'h123;
    tick();
    check("bg_before", {20'd0, vga_r, vga_g, vga_b}, {20'd0, 12'hFFF});
    bg_load = 1'b0;
    tick();
    check("bg_after", {20'd0, vga_r, vga_g, vga_b}, {20'd0, 12'h123});
    visible = 1'b0;
    set_layers(4'b1111, 12'h456, 12'h789, 12'hABC, 12'hDEF);
    tick();
    tick();
    check("blank_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);

    // Asynchronous reset mid-cycle with a collision pending
    visible = 1'b1;
    set_layers(4'b0011, 12'h0F0, 12'h00F, 12'h0, 12'h0);
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", got_all(), reset_rec());
    model_reset();
    bg_load = 1'b1;
    bg_rgb_in = 12'hABC;
    tick();
    tick();
    #3 reset_n = 1'b1;
    bg_load = 1'b0;
    set_layers(4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);
    tick();
    tick();
    check("post_reset_bg", {20'd0, vga_r, vga_g, vga_b}, {20'd0, 12'hFFF});
    boundary();
    check("post_reset_nopulse", {30'd0, collision_frame, collision_pulse}, 32'd0);
    vsync_in = ~ACT;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      visible = ($urandom_range(0, 7) != 0);
      hsync_in = ($urandom_range(0, 15) == 0) ? ACT : ~ACT;
      if ($urandom_range(0, 24) == 0) vsync_in = ~vsync_in;
      layer_visible = 4'($urandom);
      for (int i = 0; i < 4; i++)
        layer_rgb[i*12 +: 12] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
      bg_load = ($urandom_range(0, 49) == 0);
      bg_rgb_in = 12'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
